memtrace_sched: RTL and testbench
=================================

MEMTRACE_SCHED -- requirements
Module: memtrace_sched

Interface
REQ-001 Parameter NUM_LANES, default 4, number of per-thread trace consumers (1..64).
REQ-002 Parameter ADDR_W, default 32, record address width (fixed 32 in this revision).
REQ-003 Port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 Port trace_read_valid  input  1  trace byte stream valid, from the trace reader.
REQ-006 Port trace_read_ready  output  1  byte accepted when valid&&ready.
REQ-007 Port trace_read_bits  input  8  trace byte.
REQ-008 Port lane_valid  output  NUM_LANES  one-hot record valid, indexed by lane.
REQ-009 Port lane_ready  input  NUM_LANES  per-lane accept.
REQ-010 Port lane_addr  output  32  record address, shared by all lanes.
REQ-011 Port lane_store  output  1  1=store, 0=load, shared.
REQ-012 Port lane_size  output  3  log2 access bytes, shared.
REQ-013 Port done  output  1  end-of-trace record dispatched; sticky.
REQ-014 Port error  output  1  sticky: a record named a lane >= NUM_LANES.
REQ-015 Port drop_count  output  8  dropped-record count, saturates at 255.
REQ-016 Port stat_records / stat_stalls  output  32 each  dispatched-record and lane-stall counters.

Function
REQ-017 Record = 6 bytes in stream order: header, addr[7:0], addr[15:8], addr[23:16], addr[31:24], size byte.
REQ-018 Header: bit7 = eot, bit6 = store, bits[5:0] = lane id; size byte bits[2:0] = lane_size, bits[7:3] ignored.
REQ-019 FSM states COLLECT, DISPATCH, DONE; reset state COLLECT with byte counter 0.
REQ-020 COLLECT: trace_read_ready=1; each accepted byte is stored at counter position, counter increments.
REQ-021 Sixth accepted byte: counter wraps to 0, next state DISPATCH; record visible on lane outputs the following cycle (latency 1).
REQ-022 DISPATCH: trace_read_ready=0; lane_valid[lane id]=1, others 0; lane_addr/store/size stable until handshake.
REQ-023 DISPATCH handshake on lane_ready[lane id]: next state DONE if eot=1, else COLLECT; lane_ready on other lanes is ignored.
REQ-024 Lane id >= NUM_LANES: no lane_valid asserted; record is dropped in one cycle; error set; drop_count incremented (saturating); eot on a dropped record still moves to DONE.
REQ-025 DONE: trace_read_ready=0, lane_valid=0, done=1 until reset.
REQ-026 Minimum record period 7 cycles (6 COLLECT + 1 DISPATCH with lane_ready high).
REQ-027 trace_read_valid low in COLLECT holds the counter; partial records persist indefinitely.

Reset
REQ-028 reset low asynchronously forces COLLECT, counter 0, trace_read_ready=0 while asserted, lane_valid=0, lane_addr=0, lane_store=0, lane_size=0, done=0, error=0, drop_count=0, stat counters=0.
REQ-029 Reset mid-record or mid-dispatch discards the partial/pending record; first byte after release is treated as a header.
REQ-030 trace_read_ready rises no earlier than the first clock edge after reset release.

Configuration
REQ-031 Macro MEMTRACE_SCHED_STATS_EN defined: stat_records increments on each lane handshake; stat_stalls increments each DISPATCH cycle with lane_ready[lane id]=0; both wrap at 2^32.
REQ-032 Macro undefined: stat_records and stat_stalls are constant 0 and no counter flops exist; all other behaviour identical.

Structure
REQ-033 Package memtrace_pkg holds REC_BYTES=6, header bit positions (EOT_BIT, STORE_BIT, LANE_LSB/MSB), the record struct (eot, store, lane, addr, size) and the FSM state enum.
REQ-034 Sub-module memtrace_rec_asm performs byte collection (counter, byte registers, record-complete pulse); memtrace_sched holds the FSM, routing, error and stats logic.

Verification
REQ-035 Bytes 02,78,56,34,12,02 back-to-back, lane_ready=all 1 -> lane_valid=0100, addr=0x12345678, store=0, size=2, one cycle after byte 6; trace_read_ready=0 that cycle.
REQ-036 Header 0x41 record, lane_ready[1] low for 5 cycles -> lane_valid held 0010, outputs stable, stat_stalls=5 (STATS_EN), trace_read_ready=0 throughout.
REQ-037 Header 0x3F with NUM_LANES=4 -> no lane_valid, error=1, drop_count=1; next record dispatches normally.
REQ-038 Header 0x83 record, lane_ready[3]=1 -> handshake, done=1, trace_read_ready=0 for all later cycles despite valid input.
REQ-039 reset low after 3 bytes of a record, then release and send a full record -> only the new record is dispatched, with correct fields.
REQ-040 300 records with bad lane id -> drop_count saturates at 255, error stays 1.

Source files
------------

// File: rtl/memtrace_pkg.sv
// memtrace_pkg: shared types and constants for the memory-trace scheduler.
//   REC_BYTES            bytes per trace record (header, addr[7:0..31:24], size)
//   EOT_BIT / STORE_BIT  header flag bit positions
//   LANE_LSB / LANE_MSB  header lane-id field
//   rec_t                decoded record (eot, store, lane, addr, size)
//   state_t              scheduler FSM states
package memtrace_pkg;

    localparam int REC_BYTES = 6;
    localparam int EOT_BIT   = 7;
    localparam int STORE_BIT = 6;
    localparam int LANE_LSB  = 0;
    localparam int LANE_MSB  = 5;
    localparam int LANE_W    = LANE_MSB - LANE_LSB + 1;

    typedef struct packed {
        logic              eot;
        logic              store;
        logic [LANE_W-1:0] lane;
        logic [31:0]       addr;
        logic [2:0]        size;
    } rec_t;

    typedef enum logic [1:0] {
        ST_COLLECT  = 2'd0,
        ST_DISPATCH = 2'd1,
        ST_DONE     = 2'd2
    } state_t;

endpackage

// File: rtl/memtrace_rec_asm.sv
// memtrace_rec_asm: assembles trace bytes into a record.
//   clock, reset   clock and asynchronous active-low reset
//   byte_en        a byte is accepted this cycle
//   byte_in        the accepted byte
//   rec_done       pulse: this byte completes a record
//   rec_out        decoded record, valid while rec_done is high (the size
//                  field is taken straight from byte_in, the final byte)
module memtrace_rec_asm
    import memtrace_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       byte_en,
    input  logic [7:0] byte_in,
    output logic       rec_done,
    output rec_t       rec_out
);

    localparam int          HOLD_BYTES = REC_BYTES - 1;
    localparam logic [2:0]  LAST_IDX   = 3'(REC_BYTES - 1);

    logic [2:0] cnt_q, cnt_d;
    logic [7:0] byte_q [HOLD_BYTES];
    logic [7:0] byte_d [HOLD_BYTES];

    assign rec_done = byte_en && (cnt_q == LAST_IDX);

    always_comb begin
        cnt_d  = cnt_q;
        byte_d = byte_q;
        if (byte_en) begin
            for (int i = 0; i < HOLD_BYTES; i++) begin
                if (cnt_q == 3'(i)) byte_d[i] = byte_in;
            end
            cnt_d = rec_done ? 3'd0 : cnt_q + 3'd1;
        end
    end

    always_comb begin
        rec_out.eot   = byte_q[0][EOT_BIT];
        rec_out.store = byte_q[0][STORE_BIT];
        rec_out.lane  = byte_q[0][LANE_MSB:LANE_LSB];
        rec_out.addr  = {byte_q[4], byte_q[3], byte_q[2], byte_q[1]};
        rec_out.size  = byte_in[2:0];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) cnt_q <= 3'd0;
        else        cnt_q <= cnt_d;
    end

    // Byte holding registers carry data only; a reset restarts the counter,
    // so stale bytes are always overwritten before they are used.
    always_ff @(posedge clock) begin
        byte_q <= byte_d;
    end

endmodule

// File: rtl/memtrace_sched.sv
// memtrace_sched: routes 6-byte memory-trace records to per-thread lanes.
//   clock, reset       clock and asynchronous active-low reset
//   trace_read_*       byte stream in (valid/ready/bits)
//   lane_valid         one-hot record valid per lane
//   lane_ready         per-lane accept
//   lane_addr/store/size  shared record fields
//   done               sticky: end-of-trace record dispatched
//   error              sticky: a record named a lane >= NUM_LANES
//   drop_count         dropped records, saturating at 255
//   stat_records/stat_stalls  handshake / stall counters
// Optional feature macro: MEMTRACE_SCHED_STATS_EN enables the stat counters;
// without it both stat outputs are tied to zero.
module memtrace_sched
    import memtrace_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int ADDR_W    = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 trace_read_valid,
    output logic                 trace_read_ready,
    input  logic [7:0]           trace_read_bits,
    output logic [NUM_LANES-1:0] lane_valid,
    input  logic [NUM_LANES-1:0] lane_ready,
    output logic [ADDR_W-1:0]    lane_addr,
    output logic                 lane_store,
    output logic [2:0]           lane_size,
    output logic                 done,
    output logic                 error,
    output logic [7:0]           drop_count,
    output logic [31:0]          stat_records,
    output logic [31:0]          stat_stalls
);

    state_t     state_q, state_d;
    rec_t       rec_q, rec_d;
    logic       ready_en_q;
    logic       error_q, error_d;
    logic [7:0] drop_q, drop_d;

    logic                 byte_en;
    logic                 rec_done;
    rec_t                 rec_asm;
    logic [NUM_LANES-1:0] lane_hot;
    logic                 lane_ok;
    logic                 in_dispatch;
    logic                 handshake;

    // ready_en_q holds ready low until the first edge after reset release.
    assign trace_read_ready = (state_q == ST_COLLECT) && ready_en_q;
    assign byte_en          = trace_read_valid && trace_read_ready;

    memtrace_rec_asm u_rec_asm (
        .clock    (clock),
        .reset    (reset),
        .byte_en  (byte_en),
        .byte_in  (trace_read_bits),
        .rec_done (rec_done),
        .rec_out  (rec_asm)
    );

    // An out-of-range lane id decodes to an all-zero one-hot.
    always_comb begin
        lane_hot = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_hot[i] = (rec_q.lane == LANE_W'(i));
        end
    end

    assign lane_ok     = |lane_hot;
    assign in_dispatch = (state_q == ST_DISPATCH);
    assign handshake   = in_dispatch && |(lane_hot & lane_ready);

    assign lane_valid  = in_dispatch ? lane_hot : '0;
    assign lane_addr   = ADDR_W'(rec_q.addr);
    assign lane_store  = rec_q.store;
    assign lane_size   = rec_q.size;
    assign done        = (state_q == ST_DONE);
    assign error       = error_q;
    assign drop_count  = drop_q;

    always_comb begin
        state_d = state_q;
        rec_d   = rec_q;
        error_d = error_q;
        drop_d  = drop_q;
        case (state_q)
            ST_COLLECT: begin
                if (rec_done) begin
                    rec_d   = rec_asm;
                    state_d = ST_DISPATCH;
                end
            end
            ST_DISPATCH: begin
                if (!lane_ok) begin
                    error_d = 1'b1;
                    if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
                    state_d = rec_q.eot ? ST_DONE : ST_COLLECT;
                end else if (handshake) begin
                    state_d = rec_q.eot ? ST_DONE : ST_COLLECT;
                end
            end
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_COLLECT;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_COLLECT;
            rec_q      <= '0;
            ready_en_q <= 1'b0;
            error_q    <= 1'b0;
            drop_q     <= 8'd0;
        end else begin
            state_q    <= state_d;
            rec_q      <= rec_d;
            ready_en_q <= 1'b1;
            error_q    <= error_d;
            drop_q     <= drop_d;
        end
    end

`ifdef MEMTRACE_SCHED_STATS_EN
    logic [31:0] stat_records_q, stat_records_d;
    logic [31:0] stat_stalls_q, stat_stalls_d;

    // Stalls count only for in-range lanes; a dropped record never stalls.
    always_comb begin
        stat_records_d = stat_records_q;
        stat_stalls_d  = stat_stalls_q;
        if (handshake)                           stat_records_d = stat_records_q + 32'd1;
        if (in_dispatch && lane_ok && !handshake) stat_stalls_d = stat_stalls_q + 32'd1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stat_records_q <= 32'd0;
            stat_stalls_q  <= 32'd0;
        end else begin
            stat_records_q <= stat_records_d;
            stat_stalls_q  <= stat_stalls_d;
        end
    end

    assign stat_records = stat_records_q;
    assign stat_stalls  = stat_stalls_q;
`else
    assign stat_records = 32'd0;
    assign stat_stalls  = 32'd0;
`endif

endmodule

// File: tb/tb_memtrace_sched.sv
// tb_memtrace_sched: directed self-checking bench for memtrace_sched
// (NUM_LANES = 4). Inputs change and outputs are sampled 1ns after the
// rising clock edge.
module tb_memtrace_sched;

    logic        clock;
    logic        reset;
    logic        trace_read_valid;
    logic        trace_read_ready;
    logic [7:0]  trace_read_bits;
    logic [3:0]  lane_valid;
    logic [3:0]  lane_ready;
    logic [31:0] lane_addr;
    logic        lane_store;
    logic [2:0]  lane_size;
    logic        done;
    logic        error;
    logic [7:0]  drop_count;
    logic [31:0] stat_records;
    logic [31:0] stat_stalls;

    int checks = 0;
    int errors = 0;

    memtrace_sched #(.NUM_LANES(4), .ADDR_W(32)) dut (
        .clock            (clock),
        .reset            (reset),
        .trace_read_valid (trace_read_valid),
        .trace_read_ready (trace_read_ready),
        .trace_read_bits  (trace_read_bits),
        .lane_valid       (lane_valid),
        .lane_ready       (lane_ready),
        .lane_addr        (lane_addr),
        .lane_store       (lane_store),
        .lane_size        (lane_size),
        .done             (done),
        .error            (error),
        .drop_count       (drop_count),
        .stat_records     (stat_records),
        .stat_stalls      (stat_stalls)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Sends one record back-to-back; on return the record has just been
    // accepted (DUT should now be presenting it).
    task automatic send_record(input logic [7:0] hdr, input logic [31:0] addr,
                               input logic [7:0] szb);
        logic [7:0] b [6];
        b[0] = hdr;         b[1] = addr[7:0];   b[2] = addr[15:8];
        b[3] = addr[23:16]; b[4] = addr[31:24]; b[5] = szb;
        for (int i = 0; i < 6; i++) begin
            trace_read_valid = 1'b1;
            trace_read_bits  = b[i];
            checks++;
            if (trace_read_ready !== 1'b1) begin
                errors++;
                $display("FAIL collect_ready byte %0d: got %b expected 1", i, trace_read_ready);
            end
            step();
        end
        trace_read_valid = 1'b0;
        trace_read_bits  = 8'h00;
    endtask

    task automatic test_reset();
        reset = 1'b0; trace_read_valid = 1'b0; trace_read_bits = 8'h00; lane_ready = 4'h0;
        step(); step();
        checks++;
        if ({trace_read_ready, lane_valid, done, error} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got rdy=%b lv=%b done=%b err=%b expected all 0",
                     trace_read_ready, lane_valid, done, error);
        end
        checks++;
        if ({lane_addr, lane_store, lane_size, drop_count} !== 44'h0) begin
            errors++;
            $display("FAIL reset_data: got addr=%h st=%b sz=%h drop=%0d expected 0",
                     lane_addr, lane_store, lane_size, drop_count);
        end
        checks++;
        if ({stat_records, stat_stalls} !== 64'h0) begin
            errors++;
            $display("FAIL reset_stats: got rec=%0d stall=%0d expected 0", stat_records, stat_stalls);
        end
        #3 reset = 1'b1;  // release mid-cycle
        #1;
        checks++;
        if (trace_read_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge: got %b expected 0", trace_read_ready);
        end
        step();
        checks++;
        if (trace_read_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_edge: got %b expected 1", trace_read_ready);
        end
    endtask

    task automatic test_basic();
        lane_ready = 4'hF;
        send_record(8'h02, 32'h1234_5678, 8'h02);
        checks++;
        if (lane_valid !== 4'b0100 || trace_read_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_valid: got lv=%b rdy=%b expected lv=0100 rdy=0", lane_valid, trace_read_ready);
        end
        checks++;
        if (lane_addr !== 32'h1234_5678 || lane_store !== 1'b0 || lane_size !== 3'd2) begin
            errors++;
            $display("FAIL basic_fields: got addr=%h st=%b sz=%0d expected 12345678/0/2",
                     lane_addr, lane_store, lane_size);
        end
        step();
        checks++;
        if (lane_valid !== 4'b0000 || trace_read_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_release: got lv=%b rdy=%b expected 0000/1", lane_valid, trace_read_ready);
        end
    endtask

    task automatic test_stall();
        lane_ready = 4'b1101;
        send_record(8'h41, 32'hDEAD_BEEF, 8'hFB);  // size bits[7:3] ignored -> 3
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (lane_valid !== 4'b0010 || trace_read_ready !== 1'b0 || lane_addr !== 32'hDEAD_BEEF
                || lane_store !== 1'b1 || lane_size !== 3'd3) begin
                errors++;
                $display("FAIL stall_hold cycle %0d: got lv=%b rdy=%b addr=%h st=%b sz=%0d expected 0010/0/deadbeef/1/3",
                         i, lane_valid, trace_read_ready, lane_addr, lane_store, lane_size);
            end
            step();
        end
        lane_ready = 4'b0010;
        checks++;
`ifdef MEMTRACE_SCHED_STATS_EN
        if (stat_stalls !== 32'd5) begin
            errors++;
            $display("FAIL stall_count: got %0d expected 5", stat_stalls);
        end
`else
        if (stat_stalls !== 32'd0) begin
            errors++;
            $display("FAIL stall_count: got %0d expected 0", stat_stalls);
        end
`endif
        step();
        checks++;
        if (lane_valid !== 4'b0000 || trace_read_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: got lv=%b rdy=%b expected 0000/1", lane_valid, trace_read_ready);
        end
        checks++;
`ifdef MEMTRACE_SCHED_STATS_EN
        if (stat_records !== 32'd2) begin
            errors++;
            $display("FAIL record_count: got %0d expected 2", stat_records);
        end
`else
        if (stat_records !== 32'd0) begin
            errors++;
            $display("FAIL record_count: got %0d expected 0", stat_records);
        end
`endif
    endtask

    task automatic test_drop();
        lane_ready = 4'hF;
        send_record(8'h3F, 32'h0000_0000, 8'h00);
        checks++;
        if (lane_valid !== 4'b0000 || trace_read_ready !== 1'b0 || error !== 1'b0) begin
            errors++;
            $display("FAIL drop_dispatch: got lv=%b rdy=%b err=%b expected 0000/0/0",
                     lane_valid, trace_read_ready, error);
        end
        step();
        checks++;
        if (error !== 1'b1 || drop_count !== 8'd1 || trace_read_ready !== 1'b1) begin
            errors++;
            $display("FAIL drop_after: got err=%b drop=%0d rdy=%b expected 1/1/1",
                     error, drop_count, trace_read_ready);
        end
        send_record(8'h00, 32'h0000_0010, 8'h01);
        checks++;
        if (lane_valid !== 4'b0001 || lane_addr !== 32'h10 || lane_size !== 3'd1) begin
            errors++;
            $display("FAIL drop_next: got lv=%b addr=%h sz=%0d expected 0001/10/1",
                     lane_valid, lane_addr, lane_size);
        end
        step();
    endtask

    task automatic test_reset_mid();
        lane_ready = 4'hF;
        for (int i = 0; i < 3; i++) begin
            trace_read_valid = 1'b1;
            trace_read_bits  = 8'h41 + 8'(i);
            step();
        end
        trace_read_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        checks++;
        if (trace_read_ready !== 1'b0 || lane_valid !== 4'b0 || error !== 1'b0
            || drop_count !== 8'd0 || lane_addr !== 32'h0) begin
            errors++;
            $display("FAIL midreset_async: got rdy=%b lv=%b err=%b drop=%0d addr=%h expected all 0",
                     trace_read_ready, lane_valid, error, drop_count, lane_addr);
        end
        step();
        reset = 1'b1;
        step();
        send_record(8'h02, 32'hCAFE_F00D, 8'h00);
        checks++;
        if (lane_valid !== 4'b0100 || lane_addr !== 32'hCAFE_F00D || lane_store !== 1'b0
            || lane_size !== 3'd0) begin
            errors++;
            $display("FAIL midreset_record: got lv=%b addr=%h st=%b sz=%0d expected 0100/cafef00d/0/0",
                     lane_valid, lane_addr, lane_store, lane_size);
        end
        step();
    endtask

    task automatic test_saturate();
        lane_ready = 4'hF;
        for (int i = 0; i < 300; i++) begin
            send_record(8'h3E, 32'(i), 8'h00);
            step();
            if (i == 254) begin
                checks++;
                if (drop_count !== 8'd255) begin
                    errors++;
                    $display("FAIL drop_255: got %0d expected 255", drop_count);
                end
            end
        end
        checks++;
        if (drop_count !== 8'd255 || error !== 1'b1) begin
            errors++;
            $display("FAIL drop_saturate: got drop=%0d err=%b expected 255/1", drop_count, error);
        end
    endtask

    task automatic test_eot();
        lane_ready = 4'hF;
        send_record(8'h83, 32'h0BAD_CAFE, 8'h04);
        checks++;
        if (lane_valid !== 4'b1000 || done !== 1'b0) begin
            errors++;
            $display("FAIL eot_dispatch: got lv=%b done=%b expected 1000/0", lane_valid, done);
        end
        step();
        trace_read_valid = 1'b1;
        trace_read_bits  = 8'h01;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (done !== 1'b1 || trace_read_ready !== 1'b0 || lane_valid !== 4'b0) begin
                errors++;
                $display("FAIL eot_done cycle %0d: got done=%b rdy=%b lv=%b expected 1/0/0000",
                         i, done, trace_read_ready, lane_valid);
            end
            step();
        end
        trace_read_valid = 1'b0;
    endtask

    task automatic test_eot_dropped();
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
        lane_ready = 4'hF;
        send_record(8'hBF, 32'h0, 8'h00);
        step();
        checks++;
        if (done !== 1'b1 || error !== 1'b1 || drop_count !== 8'd1 || trace_read_ready !== 1'b0) begin
            errors++;
            $display("FAIL eot_drop: got done=%b err=%b drop=%0d rdy=%b expected 1/1/1/0",
                     done, error, drop_count, trace_read_ready);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_drop();
        test_reset_mid();
        test_saturate();
        test_eot();
        test_eot_dropped();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
